// File: rtl/bram_bist_pkg.sv
// Shared definitions for bram_bist: engine state encoding, status width and
// the init / pattern / inverse-pattern image helpers.
package bram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_INIT = 3'd1,
    ST_WR_PAT  = 3'd2,
    ST_RD_PAT  = 3'd3,
    ST_WR_INV  = 3'd4,
    ST_RD_INV  = 3'd5,
    ST_WR_INIT = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

  localparam int ERR_W = 16;
  // Helpers work on a wide word; callers keep the low DATA_W bits (DATA_W < MAX_W).
  localparam int MAX_W = 256;
  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t init_f(input word_t a, input int data_w, input int addr_w);
    word_t r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < addr_w && i < data_w) r[i] = a[i];
      else r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic word_t pat_f(input logic [31:0] seed, input word_t a,
                                  input int data_w, input int addr_w);
    word_t r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < data_w) begin
        r[i] = a[i % addr_w];
        if (i < 32) r[i] = r[i] ^ seed[i];
        else r[i] = r[i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic word_t inv_f(input logic [31:0] seed, input word_t a,
                                  input int data_w, input int addr_w);
    word_t p;
    word_t r;
    p = pat_f(seed, a, data_w, addr_w);
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < data_w) r[i] = ~p[i];
      else r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_tdp.sv
// True-dual-port byte-write RAM: port A read-only, port B read-first with byte
// enables; both reads registered. Powers up holding init(a) = a.
module bram_tdp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     addr_a,
  output logic [DATA_W-1:0]     q_a,
  input  logic [DATA_W/8-1:0]   we_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_W-1:0]     din_b,
  output logic [DATA_W-1:0]     q_b
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] q_a_q;
  logic [DATA_W-1:0] q_b_q;

  // Power-on image loaded into the array at configuration time.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] = DATA_W'(i);
    end
  end

  // Port A registered read.
  always_ff @(posedge clk) begin
    q_a_q <= mem_q[addr_a];
  end

  // Port B: old word is captured before the byte-lane update lands.
  always @(posedge clk) begin
    q_b_q <= mem_q[addr_b];
    for (int i = 0; i < NB; i++) begin
      if (we_b[i]) mem_q[addr_b][8*i +: 8] <= din_b[8*i +: 8];
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: rtl/bram_bist.sv
// bram_bist: dual-port BRAM with a march self-test engine and VIO-style status.
// Define BRAM_BIST_ERR_INJECT_EN to add the inject input that flips one WR_PAT write.
module bram_bist
  import bram_bist_pkg::*;
#(
  parameter int          ADDR_W = 10,
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'hA5C3_5A3C
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
`ifdef BRAM_BIST_ERR_INJECT_EN
  input  logic                inject,
`endif
  input  logic [ADDR_W-1:0]   addr_a,
  output logic [DATA_W-1:0]   q_a,
  input  logic [DATA_W/8-1:0] we_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   din_b,
  output logic [DATA_W-1:0]   q_b,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2:0]          phase,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;
  localparam int CNT_W = ADDR_W + 1;

  state_e              state_q, state_d, state_nx;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                cmp_err_q, cmp_err_d;
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
  logic [ERR_W-1:0]    err_count_q, err_count_d;
  logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic [ADDR_W-1:0]   eng_addr;
  logic                eng_wr, eng_rd, inj_hit;
  word_t               wr_img, exp_img;
  logic [DATA_W-1:0]   wr_data, exp_data;
  logic [NB-1:0]       ram_we_b;
  logic [ADDR_W-1:0]   ram_addr_a, ram_addr_b;
  logic [DATA_W-1:0]   ram_din_b;
  logic                unused_img;

  assign eng_addr = cnt_q[ADDR_W-1:0];
  assign eng_wr   = (state_q == ST_WR_PAT) || (state_q == ST_WR_INV) || (state_q == ST_WR_INIT);
  assign eng_rd   = (state_q == ST_RD_INIT) || (state_q == ST_RD_PAT) || (state_q == ST_RD_INV);

`ifdef BRAM_BIST_ERR_INJECT_EN
  logic inj_arm_q, inj_arm_d;
  assign inj_hit = inj_arm_q && (state_q == ST_WR_PAT);

  // Arm on inject; disarm once the corrupted write has been issued.
  always_comb begin
    inj_arm_d = inj_arm_q;
    if (inject) inj_arm_d = 1'b1;
    else if (inj_hit) inj_arm_d = 1'b0;
    else inj_arm_d = inj_arm_q;
  end

  // Inject flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) inj_arm_q <= 1'b0;
    else inj_arm_q <= inj_arm_d;
  end
`else
  assign inj_hit = 1'b0;
`endif

  // Write image for the current address and expected image for the returning read.
  always_comb begin
    wr_img  = '0;
    exp_img = '0;
    case (state_q)
      ST_WR_PAT:  wr_img = pat_f(SEED, word_t'(eng_addr), DATA_W, ADDR_W);
      ST_WR_INV:  wr_img = inv_f(SEED, word_t'(eng_addr), DATA_W, ADDR_W);
      ST_WR_INIT: wr_img = init_f(word_t'(eng_addr), DATA_W, ADDR_W);
      default:    wr_img = '0;
    endcase
    case (state_q)
      ST_RD_INIT: exp_img = init_f(word_t'(rd_addr_q), DATA_W, ADDR_W);
      ST_RD_PAT:  exp_img = pat_f(SEED, word_t'(rd_addr_q), DATA_W, ADDR_W);
      ST_RD_INV:  exp_img = inv_f(SEED, word_t'(rd_addr_q), DATA_W, ADDR_W);
      default:    exp_img = '0;
    endcase
  end

  assign wr_data    = wr_img[DATA_W-1:0] ^ {{(DATA_W-1){1'b0}}, inj_hit};
  assign exp_data   = exp_img[DATA_W-1:0];
  assign unused_img = ^{wr_img, exp_img};

  // While busy the engine owns both ports and manual writes are dropped.
  assign ram_addr_a = busy_q ? eng_addr : addr_a;
  assign ram_addr_b = busy_q ? eng_addr : addr_b;
  assign ram_din_b  = busy_q ? wr_data  : din_b;
  assign ram_we_b   = busy_q ? (eng_wr ? {NB{1'b1}} : {NB{1'b0}}) : we_b;

  bram_tdp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk    (clk),
    .addr_a (ram_addr_a),
    .q_a    (q_a),
    .we_b   (ram_we_b),
    .addr_b (ram_addr_b),
    .din_b  (ram_din_b),
    .q_b    (q_b)
  );

  // Phase successor once the current phase has finished.
  always_comb begin
    case (state_q)
      ST_RD_INIT: state_nx = ST_DONE;
      ST_WR_PAT:  state_nx = ST_RD_PAT;
      ST_RD_PAT:  state_nx = ST_WR_INV;
      ST_WR_INV:  state_nx = ST_RD_INV;
      ST_RD_INV:  state_nx = ST_WR_INIT;
      ST_WR_INIT: state_nx = ST_DONE;
      default:    state_nx = state_q;
    endcase
  end

  // Sequencing, read/compare pipeline and status next-state.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    rd_addr_d        = eng_addr;
    cmp_addr_d       = rd_addr_q;
    if (eng_rd) rd_vld_d = (cnt_q < CNT_W'(DEPTH));
    else rd_vld_d = 1'b0;
    if (rd_vld_q) cmp_err_d = (q_a != exp_data);
    else cmp_err_d = 1'b0;
    if (cmp_err_q) begin
      if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + ERR_W'(1);
      else err_count_d = err_count_q;
      if (err_count_q == {ERR_W{1'b0}}) first_err_addr_d = cmp_addr_q;
      else first_err_addr_d = first_err_addr_q;
    end else begin
      err_count_d = err_count_q;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_count_d      = '0;
          first_err_addr_d = '0;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          busy_d           = 1'b1;
          cnt_d            = '0;
          state_d          = mode ? ST_RD_INIT : ST_WR_PAT;
        end else begin
          state_d = state_q;
        end
      end
      ST_RD_INIT, ST_RD_PAT, ST_RD_INV: begin
        if (cnt_q == CNT_W'(DEPTH + 1)) begin
          cnt_d   = '0;
          state_d = state_nx;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_PAT, ST_WR_INV, ST_WR_INIT: begin
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = state_nx;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = (err_count_d == {ERR_W{1'b0}});
    end else begin
      busy_d = busy_d;
    end
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      rd_vld_q         <= 1'b0;
      rd_addr_q        <= '0;
      cmp_err_q        <= 1'b0;
      cmp_addr_q       <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      rd_vld_q         <= rd_vld_d;
      rd_addr_q        <= rd_addr_d;
      cmp_err_q        <= cmp_err_d;
      cmp_addr_q       <= cmp_addr_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign phase          = state_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_bram_bist.sv
// Self-checking bench for bram_bist against a word-array model of the memory.
// Define BRAM_BIST_ERR_INJECT_EN to also exercise the inject port.
module tb_bram_bist;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int LIMIT  = 20000;
  localparam logic [31:0] SEED = 32'hA5C3_5A3C;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
`ifdef BRAM_BIST_ERR_INJECT_EN
  logic              inject = 1'b0;
`endif
  logic [ADDR_W-1:0] addr_a = '0;
  logic [DATA_W-1:0] q_a;
  logic [3:0]        we_b = 4'h0;
  logic [ADDR_W-1:0] addr_b = '0;
  logic [DATA_W-1:0] din_b = '0;
  logic [DATA_W-1:0] q_b;
  logic              busy, done, pass;
  logic [2:0]        phase;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];
  int          ph_len [8];
  int          run_cyc;

  always #5 clk = ~clk;

  bram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
`ifdef BRAM_BIST_ERR_INJECT_EN
    .inject(inject),
`endif
    .addr_a(addr_a), .q_a(q_a), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .q_b(q_b),
    .busy(busy), .done(done), .pass(pass), .phase(phase),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  function automatic logic [31:0] pat_m(input int a);
    logic [9:0]  av;
    logic [39:0] r;
    av = a[9:0];
    r  = {av, av, av, av};
    return SEED ^ r[31:0];
  endfunction

  // Expected outcome of an init check over the current model contents.
  task automatic model_init_check(output int n, output int first);
    n = 0;
    first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (model[a] !== 32'(a)) begin
        if (n == 0) first = a;
        n++;
      end
    end
  endtask

  // Pulse start, then count busy cycles (per phase) until the run ends.
  task automatic run(input logic m, input bit disturb);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_cyc = 0;
    for (int i = 0; i < 8; i++) ph_len[i] = 0;
    while (busy === 1'b1 && run_cyc < LIMIT) begin
      if (disturb && run_cyc == 100) begin
        we_b = 4'hF; addr_b = 10'd100; din_b = 32'h0; start = 1'b1; addr_a = 10'd3;
      end else begin
        we_b = 4'h0; start = 1'b0;
      end
      ph_len[phase]++;
      run_cyc++;
      @(negedge clk);
    end
    we_b = 4'h0;
    start = 1'b0;
    checks++;
    if (run_cyc >= LIMIT) begin
      errors++;
      $display("FAIL run_timeout got %0d cycles limit %0d", run_cyc, LIMIT);
    end
  endtask

  task automatic check_init_run(input string tag, input int exp_cyc);
    int n, f;
    model_init_check(n, f);
    run(1'b1, 1'b0);
    checks++;
    if (run_cyc !== exp_cyc) begin errors++; $display("FAIL %s_cycles got %0d exp %0d", tag, run_cyc, exp_cyc); end
    checks++;
    if (err_count !== 16'(n)) begin errors++; $display("FAIL %s_err_count got %0d exp %0d", tag, err_count, n); end
    checks++;
    if (n != 0 && first_err_addr !== 10'(f)) begin errors++; $display("FAIL %s_first_err got %0d exp %0d", tag, first_err_addr, f); end
    checks++;
    if (pass !== (n == 0) || done !== 1'b1) begin errors++; $display("FAIL %s_pass_done got %b%b exp %b1", tag, pass, done, n == 0); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
    checks++; if (first_err_addr !== 10'd0) begin errors++; $display("FAIL reset_first got %0d exp 0", first_err_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_march();
    int exp_len [8];
    exp_len = '{0, 0, 1024, 1026, 1024, 1026, 1024, 0};
    run(1'b0, 1'b1);
    for (int m = 0; m < DEPTH; m++) model[m] = 32'(m);
    checks++;
    if (run_cyc !== 5124) begin errors++; $display("FAIL march_cycles got %0d exp 5124", run_cyc); end
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (ph_len[p] !== exp_len[p]) begin errors++; $display("FAIL march_phase%0d_len got %0d exp %0d", p, ph_len[p], exp_len[p]); end
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 16'd0 || phase !== 3'd7) begin
      errors++; $display("FAIL march_status got pass=%b err=%0d phase=%0d exp 1 0 7", pass, err_count, phase);
    end
    addr_a = 10'd5;
    @(negedge clk);
    checks++;
    if (q_a !== 32'd5) begin errors++; $display("FAIL manual_read5 got %0h exp 5", q_a); end
  endtask

  task automatic manual_write(input int a, input logic [3:0] we, input logic [31:0] d);
    @(negedge clk);
    addr_b = 10'(a); we_b = we; din_b = d;
    @(negedge clk);
    we_b = 4'h0;
    checks++;
    if (q_b !== model[a]) begin errors++; $display("FAIL read_first_q_b got %0h exp %0h", q_b, model[a]); end
    for (int l = 0; l < 4; l++) if (we[l]) model[a][8*l +: 8] = d[8*l +: 8];
  endtask

  task automatic test_byte_lane();
    manual_write(7, 4'b0010, 32'hFFFF_FFFF);
    check_init_run("byte_lane", 1026);
    checks++;
    if (err_count !== 16'd1 || first_err_addr !== 10'd7) begin
      errors++; $display("FAIL byte_lane_fixed got err=%0d first=%0d exp 1 7", err_count, first_err_addr);
    end
    run(1'b0, 1'b0);
    for (int m = 0; m < DEPTH; m++) model[m] = 32'(m);
  endtask

  task automatic test_two_errors();
    manual_write(9, 4'hF, ~32'd9);
    manual_write(3, 4'hF, ~32'd3);
    check_init_run("two_err", 1026);
    checks++;
    if (err_count !== 16'd2 || first_err_addr !== 10'd3) begin
      errors++; $display("FAIL two_err_fixed got err=%0d first=%0d exp 2 3", err_count, first_err_addr);
    end
    run(1'b0, 1'b0);
    for (int m = 0; m < DEPTH; m++) model[m] = 32'(m);
  endtask

  task automatic test_random_manual();
    int a;
    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(0, DEPTH - 1));
      manual_write(a, 4'($urandom), $urandom);
      a = int'($urandom_range(0, DEPTH - 1));
      addr_a = 10'(a);
      @(negedge clk);
      checks++;
      if (q_a !== model[a]) begin errors++; $display("FAIL rand_q_a addr %0d got %0h exp %0h", a, q_a, model[a]); end
    end
    check_init_run("rand_init", 1026);
    run(1'b0, 1'b0);
    for (int m = 0; m < DEPTH; m++) model[m] = 32'(m);
  endtask

  task automatic test_reset_mid_run();
    int w = 0;
    @(negedge clk);
    mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (phase !== 3'd3 && w < LIMIT) begin @(negedge clk); w++; end
    checks++;
    if (w >= LIMIT) begin errors++; $display("FAIL mid_reach_rd_pat got timeout exp phase 3"); end
    repeat ($urandom_range(1, 500)) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || phase !== 3'd0 || err_count !== 16'd0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got busy=%b phase=%0d err=%0d done=%b exp 0 0 0 0", busy, phase, err_count, done);
    end
    rst_n = 1'b1;
    for (int m = 0; m < DEPTH; m++) model[m] = pat_m(m);
    check_init_run("after_mid_reset", 1026);
    checks++;
    if (pass !== 1'b0) begin errors++; $display("FAIL after_mid_reset_pass got %b exp 0", pass); end
    run(1'b0, 1'b0);
    for (int m = 0; m < DEPTH; m++) model[m] = 32'(m);
  endtask

`ifdef BRAM_BIST_ERR_INJECT_EN
  task automatic test_inject();
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    run(1'b0, 1'b0);
    checks++;
    if (err_count !== 16'd1 || first_err_addr !== 10'd0 || pass !== 1'b0) begin
      errors++; $display("FAIL inject got err=%0d first=%0d pass=%b exp 1 0 0", err_count, first_err_addr, pass);
    end
    check_init_run("inject_restore", 1026);
  endtask
`endif

  initial begin
    for (int m = 0; m < DEPTH; m++) model[m] = 32'(m);
    test_reset();
    check_init_run("fresh_init", 1026);
    test_march();
    check_init_run("after_march", 1026);
    test_byte_lane();
    test_two_errors();
    test_random_manual();
    test_reset_mid_run();
`ifdef BRAM_BIST_ERR_INJECT_EN
    test_inject();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
